// File: rtl/imem_uart_loader.sv
// Boot loader: receives an 8N1 UART program image (16-bit big-endian word count, then
// big-endian 32-bit words) and writes it into imem from address 0 while holding the CPU.
module imem_uart_loader #(
   parameter int unsigned CLKS_PER_BIT = 868,
   parameter int unsigned ADDR_W       = 11,
   parameter int unsigned MAX_WORDS    = 2048
) (
   input  logic              clk_in,
   input  logic              reset,
   input  logic              uart_rx,
   output logic              im_w,
   output logic [ADDR_W-1:0] im_addr,
   output logic [31:0]       im_wdata,
   output logic              cpu_hold,
   output logic              busy,
   output logic              done,
   output logic              err
);

   localparam int unsigned     CNT_W = $clog2(CLKS_PER_BIT + 1);
   localparam logic [CNT_W-1:0] HALF = CNT_W'(CLKS_PER_BIT / 2);
   localparam logic [CNT_W-1:0] LAST = CNT_W'(CLKS_PER_BIT - 1);
   localparam logic [15:0]      MAX_N = 16'(MAX_WORDS);

   typedef enum logic [1:0] {RxIdle, RxStart, RxData, RxStop} rx_state_e;
   typedef enum logic [2:0] {LdLenHi, LdLenLo, LdWord, LdWrite, LdDone, LdError} ld_state_e;

   logic [1:0] sync_q;
   logic       rx;

   always_ff @(posedge clk_in or posedge reset) begin
      if (reset) sync_q <= 2'b11;
      else       sync_q <= {sync_q[0], uart_rx};
   end
   assign rx = sync_q[1];

   rx_state_e        rx_state_q, rx_state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [2:0]       bit_q, bit_d;
   logic [7:0]       shreg_q, shreg_d;
   logic             rx_valid, frame_err;

   always_ff @(posedge clk_in or posedge reset) begin
      if (reset) begin
         rx_state_q <= RxIdle;
         cnt_q      <= '0;
         bit_q      <= '0;
         shreg_q    <= '0;
      end else begin
         rx_state_q <= rx_state_d;
         cnt_q      <= cnt_d;
         bit_q      <= bit_d;
         shreg_q    <= shreg_d;
      end
   end

   // The detection cycle in RxIdle counts as tick 0 of the start bit.
   always_comb begin
      rx_state_d = rx_state_q;
      cnt_d      = cnt_q + CNT_W'(1);
      bit_d      = bit_q;
      shreg_d    = shreg_q;
      unique case (rx_state_q)
         RxIdle: begin
            cnt_d = CNT_W'(1);
            bit_d = '0;
            if (!rx) rx_state_d = RxStart;
         end
         RxStart: begin
            if (cnt_q == HALF) begin
               cnt_d      = '0;
               rx_state_d = rx ? RxIdle : RxData;
            end
         end
         RxData: begin
            if (cnt_q == LAST) begin
               cnt_d   = '0;
               shreg_d = {rx, shreg_q[7:1]};
               bit_d   = bit_q + 3'd1;
               if (bit_q == 3'd7) rx_state_d = RxStop;
            end
         end
         RxStop: begin
            if (cnt_q == LAST) rx_state_d = RxIdle;
         end
         default: rx_state_d = RxIdle;
      endcase
   end

   always_comb begin
      rx_valid  = (rx_state_q == RxStop) && (cnt_q == LAST) && rx;
      frame_err = (rx_state_q == RxStop) && (cnt_q == LAST) && !rx;
   end

   ld_state_e     ld_q, ld_d;
   logic [15:0]   len_q;
   logic [1:0]    idx_q;
   logic [23:0]   shift_q;
   logic [31:0]   wdata_q;
   logic [ADDR_W:0] addr_q;
   logic [15:0]   len_now;
   logic [15:0]   written;

   assign len_now = {len_q[15:8], shreg_q};
   assign written = 16'(addr_q) + 16'd1;

   always_ff @(posedge clk_in or posedge reset) begin
      if (reset) ld_q <= LdLenHi;
      else       ld_q <= ld_d;
   end

   always_comb begin
      ld_d = ld_q;
      if (frame_err && (ld_q != LdDone)) begin
         ld_d = LdError;
      end else begin
         unique case (ld_q)
            LdLenHi: if (rx_valid) ld_d = LdLenLo;
            LdLenLo: begin
               if (rx_valid) begin
                  if (len_now == 16'd0)   ld_d = LdDone;
                  else if (len_now > MAX_N) ld_d = LdError;
                  else                    ld_d = LdWord;
               end
            end
            LdWord:  if (rx_valid && (idx_q == 2'd3)) ld_d = LdWrite;
            LdWrite: ld_d = (written == len_q) ? LdDone : LdWord;
            LdDone:  ld_d = LdDone;
            LdError: ld_d = LdError;
            default: ld_d = LdError;
         endcase
      end
   end

   always_comb begin
      im_w     = (ld_q == LdWrite);
      busy     = (ld_q == LdLenLo) || (ld_q == LdWord) || (ld_q == LdWrite);
      done     = (ld_q == LdDone);
      err      = (ld_q == LdError);
      cpu_hold = (ld_q != LdDone);
      im_addr  = addr_q[ADDR_W-1:0];
      im_wdata = wdata_q;
   end

   // im_wdata only changes when a full word is assembled, so it is stable outside WRITE.
   always_ff @(posedge clk_in or posedge reset) begin
      if (reset) begin
         len_q   <= '0;
         idx_q   <= '0;
         shift_q <= '0;
         wdata_q <= '0;
         addr_q  <= '0;
      end else begin
         if (ld_q == LdLenHi && rx_valid) len_q[15:8] <= shreg_q;
         if (ld_q == LdLenLo && rx_valid) begin
            len_q[7:0] <= shreg_q;
            idx_q      <= '0;
         end
         if (ld_q == LdWord && rx_valid) begin
            idx_q   <= idx_q + 2'd1;
            shift_q <= {shift_q[15:0], shreg_q};
            if (idx_q == 2'd3) wdata_q <= {shift_q, shreg_q};
         end
         if (ld_q == LdWrite) addr_q <= addr_q + 1'b1;
      end
   end

endmodule

// File: tb/tb_imem_uart_loader.sv
// Randomized bench for imem_uart_loader: UART images are sent bit by bit and the captured
// imem writes and status flags are compared with a byte-level model of the image format.
module tb_imem_uart_loader;

   localparam int CPB    = 4;
   localparam int ADDR_W = 11;
   localparam int MAXW   = 2048;

   logic              clk = 1'b0;
   logic              reset = 1'b1;
   logic              uart_rx = 1'b1;
   logic              im_w;
   logic [ADDR_W-1:0] im_addr;
   logic [31:0]       im_wdata;
   logic              cpu_hold, busy, done, err;

   imem_uart_loader #(
      .CLKS_PER_BIT(CPB),
      .ADDR_W      (ADDR_W),
      .MAX_WORDS   (MAXW)
   ) dut (
      .clk_in  (clk),
      .reset   (reset),
      .uart_rx (uart_rx),
      .im_w    (im_w),
      .im_addr (im_addr),
      .im_wdata(im_wdata),
      .cpu_hold(cpu_hold),
      .busy    (busy),
      .done    (done),
      .err     (err)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc++;

   int n_checks = 0;
   int n_pass   = 0;

   // Write capture and timing observation
   logic [ADDR_W-1:0] cap_addr[$];
   logic [31:0]       cap_data[$];
   int last_w_cyc, done_cyc, hold_cyc, dbl;
   bit prev_w;

   always @(negedge clk) begin
      if (reset) begin
         prev_w = 1'b0;
      end else begin
         if (im_w) begin
            cap_addr.push_back(im_addr);
            cap_data.push_back(im_wdata);
            last_w_cyc = cyc;
            if (prev_w) dbl++;
         end
         prev_w = im_w;
         if (done && done_cyc < 0) done_cyc = cyc;
         if (!cpu_hold && hold_cyc < 0) hold_cyc = cyc;
      end
   end

   // Image under test and reference model results
   logic [7:0]        img[$];
   int                bad_at;
   logic [ADDR_W-1:0] exp_addr[$];
   logic [31:0]       exp_data[$];
   bit                exp_done, exp_err;

   task automatic clear_capture();
      cap_addr.delete();
      cap_data.delete();
      last_w_cyc = -100;
      done_cyc   = -1;
      hold_cyc   = -1;
      dbl        = 0;
   endtask

   task automatic apply_reset();
      reset   = 1'b1;
      uart_rx = 1'b1;
      repeat (3) @(negedge clk);
      clear_capture();
      reset = 1'b0;
      @(negedge clk);
   endtask

   task automatic send_byte(input logic [7:0] b, input bit stop_ok);
      logic [9:0] fr;
      fr = {stop_ok, b, 1'b0};
      for (int i = 0; i < 10; i++) begin
         uart_rx = fr[i];
         repeat (CPB) @(negedge clk);
      end
      uart_rx = 1'b1;
   endtask

   task automatic send_range(input int from, input int to);
      for (int i = from; i < to; i++) send_byte(img[i], i != bad_at);
   endtask

   task automatic push_word(input logic [31:0] w);
      img.push_back(w[31:24]);
      img.push_back(w[23:16]);
      img.push_back(w[15:8]);
      img.push_back(w[7:0]);
   endtask

   // Model: header gives N; word i occupies bytes 2+4i..5+4i; a bad stop bit ends the
   // image unless the load had already completed.
   task automatic model();
      int limit, n;
      exp_addr.delete();
      exp_data.delete();
      exp_done = 1'b0;
      exp_err  = 1'b0;
      limit = (bad_at >= 0) ? bad_at : img.size();
      if (limit < 2) begin
         exp_err = (bad_at >= 0);
         return;
      end
      n = img[0] * 256 + img[1];
      if (n == 0) begin
         exp_done = 1'b1;
         return;
      end
      if (n > MAXW) begin
         exp_err = 1'b1;
         return;
      end
      for (int i = 0; i < n; i++) begin
         if (2 + 4 * i + 3 < limit) begin
            exp_addr.push_back(ADDR_W'(i));
            exp_data.push_back({img[2+4*i], img[3+4*i], img[4+4*i], img[5+4*i]});
         end
      end
      if (exp_addr.size() == n) exp_done = 1'b1;
      else                      exp_err  = (bad_at >= 0);
   endtask

   task automatic wait_end();
      for (int i = 0; i < 400 && !(done || err); i++) @(negedge clk);
      repeat (10) @(negedge clk);
   endtask

   task automatic test_reset();
      reset = 1'b1;
      repeat (2) @(negedge clk);
      n_checks++;
      if ({im_w, im_addr, im_wdata} !== '0)
         $display("FAIL reset_im: got w=%b a=%h d=%h want 0/0/0", im_w, im_addr, im_wdata);
      else n_pass++;
      n_checks++;
      if ({cpu_hold, busy, done, err} !== 4'b1000)
         $display("FAIL reset_status: got hold/busy/done/err=%b%b%b%b want 1000",
                  cpu_hold, busy, done, err);
      else n_pass++;
      apply_reset();
   endtask

   task automatic test_two_words();
      apply_reset();
      img = '{8'h00, 8'h02, 8'h12, 8'h34, 8'h56, 8'h78, 8'hDE, 8'hAD, 8'hBE, 8'hEF};
      bad_at = -1;
      model();
      send_range(0, 1);
      repeat (4) @(negedge clk);
      n_checks++;
      if (busy !== 1'b1) $display("FAIL two_busy: got %b want 1", busy);
      else n_pass++;
      send_range(1, img.size());
      wait_end();
      n_checks++;
      if (cap_addr.size() != exp_addr.size())
         $display("FAIL two_count: got %0d want %0d", cap_addr.size(), exp_addr.size());
      else n_pass++;
      for (int i = 0; i < exp_addr.size() && i < cap_addr.size(); i++) begin
         n_checks++;
         if ({cap_addr[i], cap_data[i]} !== {exp_addr[i], exp_data[i]})
            $display("FAIL two_write%0d: got %h:%h want %h:%h", i, cap_addr[i], cap_data[i],
                     exp_addr[i], exp_data[i]);
         else n_pass++;
      end
      n_checks++;
      if ({done, err, cpu_hold, busy} !== {exp_done, exp_err, 2'b00})
         $display("FAIL two_status: got done/err/hold/busy=%b%b%b%b want %b%b00",
                  done, err, cpu_hold, busy, exp_done, exp_err);
      else n_pass++;
      n_checks++;
      if (done_cyc != last_w_cyc + 1 || hold_cyc != last_w_cyc + 1)
         $display("FAIL two_latency: got done@%0d hold@%0d want %0d", done_cyc, hold_cyc,
                  last_w_cyc + 1);
      else n_pass++;
      n_checks++;
      if (dbl != 0) $display("FAIL two_single_pulse: got %0d double pulses want 0", dbl);
      else n_pass++;
   endtask

   task automatic test_zero_len();
      apply_reset();
      img = '{8'h00, 8'h00};
      bad_at = -1;
      model();
      send_range(0, img.size());
      wait_end();
      n_checks++;
      if (cap_addr.size() != 0 || done !== exp_done || cpu_hold !== 1'b0 || err !== exp_err)
         $display("FAIL zero_len: got writes=%0d done=%b hold=%b err=%b want 0/%b/0/%b",
                  cap_addr.size(), done, cpu_hold, err, exp_done, exp_err);
      else n_pass++;
   endtask

   task automatic test_frame_err();
      apply_reset();
      img = '{8'h00, 8'h01, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77};
      bad_at = 4;
      model();
      send_range(0, img.size());
      wait_end();
      n_checks++;
      if (cap_addr.size() != exp_addr.size())
         $display("FAIL frame_writes: got %0d want %0d", cap_addr.size(), exp_addr.size());
      else n_pass++;
      n_checks++;
      if ({err, cpu_hold, done, busy} !== {exp_err, 1'b1, exp_done, 1'b0})
         $display("FAIL frame_status: got err/hold/done/busy=%b%b%b%b want %b1%b0",
                  err, cpu_hold, done, busy, exp_err, exp_done);
      else n_pass++;
   endtask

   task automatic test_over_len();
      apply_reset();
      img = '{8'h08, 8'h01, 8'h01, 8'h02, 8'h03, 8'h04};
      bad_at = -1;
      model();
      send_range(0, img.size());
      wait_end();
      n_checks++;
      if (cap_addr.size() != 0 || err !== exp_err || cpu_hold !== 1'b1 || done !== exp_done)
         $display("FAIL over_len: got writes=%0d err=%b hold=%b done=%b want 0/%b/1/%b",
                  cap_addr.size(), err, cpu_hold, done, exp_err, exp_done);
      else n_pass++;
   endtask

   task automatic test_glitch();
      apply_reset();
      img = '{8'h00, 8'h03};
      for (int i = 0; i < 3; i++) push_word($urandom);
      bad_at = -1;
      model();
      send_range(0, 2);
      uart_rx = 1'b0;
      repeat (2) @(negedge clk);
      uart_rx = 1'b1;
      repeat (3 * CPB) @(negedge clk);
      send_range(2, img.size());
      wait_end();
      n_checks++;
      if (cap_addr.size() != exp_addr.size())
         $display("FAIL glitch_count: got %0d want %0d", cap_addr.size(), exp_addr.size());
      else n_pass++;
      for (int i = 0; i < exp_addr.size() && i < cap_addr.size(); i++) begin
         n_checks++;
         if ({cap_addr[i], cap_data[i]} !== {exp_addr[i], exp_data[i]})
            $display("FAIL glitch_write%0d: got %h:%h want %h:%h", i, cap_addr[i],
                     cap_data[i], exp_addr[i], exp_data[i]);
         else n_pass++;
      end
      n_checks++;
      if (done !== exp_done || err !== exp_err)
         $display("FAIL glitch_status: got done=%b err=%b want %b/%b", done, err,
                  exp_done, exp_err);
      else n_pass++;
   endtask

   task automatic test_reset_mid_load();
      apply_reset();
      img = '{8'h00, 8'h02};
      push_word($urandom);
      bad_at = -1;
      send_range(0, img.size());
      repeat (10) @(negedge clk);
      n_checks++;
      if (cap_addr.size() != 1 || busy !== 1'b1)
         $display("FAIL midload_before: got writes=%0d busy=%b want 1/1", cap_addr.size(),
                  busy);
      else n_pass++;
      apply_reset();
      n_checks++;
      if ({busy, cpu_hold, im_addr} !== {2'b01, ADDR_W'(0)})
         $display("FAIL midload_reset: got busy=%b hold=%b addr=%h want 0/1/0", busy,
                  cpu_hold, im_addr);
      else n_pass++;
      img = '{8'h00, 8'h01, 8'hAA, 8'hBB, 8'hCC, 8'hDD};
      model();
      send_range(0, img.size());
      wait_end();
      n_checks++;
      if (cap_addr.size() != 1 || cap_addr[0] !== exp_addr[0] || cap_data[0] !== exp_data[0])
         $display("FAIL midload_write: got n=%0d %h:%h want 1 %h:%h", cap_addr.size(),
                  (cap_addr.size() > 0) ? cap_addr[0] : '1,
                  (cap_data.size() > 0) ? cap_data[0] : '1, exp_addr[0], exp_data[0]);
      else n_pass++;
      n_checks++;
      if (done !== exp_done || cpu_hold !== 1'b0)
         $display("FAIL midload_done: got done=%b hold=%b want %b/0", done, cpu_hold,
                  exp_done);
      else n_pass++;
   endtask

   task automatic test_random_images();
      for (int it = 0; it < 5; it++) begin
         int n;
         apply_reset();
         n = $urandom_range(1, 6);
         img = '{8'h00, 8'(n)};
         for (int i = 0; i < n; i++) push_word($urandom);
         // Extra trailing bytes must be ignored after DONE.
         img.push_back(8'($urandom));
         bad_at = (it == 3) ? $urandom_range(2, img.size() - 2) :
                  (it == 4) ? img.size() - 1 : -1;
         model();
         send_range(0, img.size());
         wait_end();
         n_checks++;
         if (cap_addr.size() != exp_addr.size())
            $display("FAIL rand%0d_count: got %0d want %0d", it, cap_addr.size(),
                     exp_addr.size());
         else n_pass++;
         for (int i = 0; i < exp_addr.size() && i < cap_addr.size(); i++) begin
            n_checks++;
            if ({cap_addr[i], cap_data[i]} !== {exp_addr[i], exp_data[i]})
               $display("FAIL rand%0d_write%0d: got %h:%h want %h:%h", it, i, cap_addr[i],
                        cap_data[i], exp_addr[i], exp_data[i]);
            else n_pass++;
         end
         n_checks++;
         if ({done, err, cpu_hold} !== {exp_done, exp_err, !exp_done} || dbl != 0)
            $display("FAIL rand%0d_status: got done/err/hold=%b%b%b dbl=%0d want %b%b%b 0",
                     it, done, err, cpu_hold, dbl, exp_done, exp_err, !exp_done);
         else n_pass++;
      end
   endtask

   initial begin
      clear_capture();
      test_reset();
      test_two_words();
      test_zero_len();
      test_frame_err();
      test_over_len();
      test_glitch();
      test_reset_mid_load();
      test_random_images();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/imem_uart_loader.md
Name: imem_uart_loader

Overview:
- Boot-time writer for the instruction memory; the CPU's instruction fetch path is read-only, and this block is the write side.
- Receives a program image over an 8N1 UART line, assembles big-endian 32-bit words and writes them to consecutive imem word addresses starting at 0.
- Holds the CPU in reset until the image is complete.
- Sits in the top level beside cpu/imem; its im_* outputs drive the imem write port, and cpu_hold is ORed into the CPU reset.

Parameters:
CLKS_PER_BIT, 868, clk_in cycles per UART bit (100 MHz / 115200); must be >= 4
ADDR_W, 11, imem word-address width
MAX_WORDS, 2048, largest accepted word count (<= 2**ADDR_W)

Ports:
clk_in  input  1  system clock, all state updates on posedge
reset  input  1  asynchronous, active-high reset
uart_rx  input  1  serial line, idle high, asynchronous to clk_in
im_w  output  1  imem write strobe, one-cycle pulse per word
im_addr  output  ADDR_W  imem word address for the current write
im_wdata  output  32  word being written
cpu_hold  output  1  1 = keep CPU in reset
busy  output  1  1 while a load is in progress (first length byte received, not yet DONE/ERROR)
done  output  1  image fully written
err  output  1  framing or length error; sticky until reset

Behaviour:
- Reset values: im_w=0, im_addr=0, im_wdata=0, cpu_hold=1, busy=0, done=0, err=0. UART FSM returns to IDLE and the loader FSM to LEN_HI. Reset mid-load discards partial data and restarts from LEN_HI.
- uart_rx passes through a 2-flop synchronizer (reset value 1) before use.
- RX FSM:
  - IDLE: waits for synchronized rx = 0.
  - START: rx is re-checked at count CLKS_PER_BIT/2. If rx = 1, the event is a glitch and the FSM returns to IDLE.
  - DATA: 8 bits are sampled LSB-first, each CLKS_PER_BIT after the previous sample.
  - STOP: sampled once. If 1, rx_valid pulses for one cycle with the byte. If 0, a framing error is reported and the FSM goes to IDLE.
- Loader FSM, advanced by rx_valid:
  - LEN_HI: stores the high byte of the word count N; busy=1.
  - LEN_LO: stores the low byte. N = 0 goes to DONE. N > MAX_WORDS goes to ERROR. Otherwise goes to WORD with byte index 0.
  - WORD: shifts bytes in MSB-first (byte 0 = bits 31:24). When the 4th byte arrives, goes to WRITE.
  - WRITE: exactly one cycle. im_w=1 with im_addr/im_wdata stable. In the next cycle im_addr increments. If words_written == N, goes to DONE; otherwise returns to WORD.
  - DONE: cpu_hold=0, done=1, busy=0. Further UART bytes are ignored. Only reset leaves this state.
  - ERROR: entered on any framing error before DONE, or on an over-length N. err=1, cpu_hold=1, busy=0. Only reset leaves this state.
- Latency:
  - im_w asserts on the cycle after rx_valid for the 4th byte.
  - cpu_hold falls the cycle after the final WRITE cycle.
- im_addr never wraps, because N <= MAX_WORDS. A framing error on a byte received while in DONE is ignored.
- im_wdata holds its last value outside WRITE. im_w is never high for two consecutive cycles.

Test Plan (bench CLKS_PER_BIT=4):
1. Send 00 02, then 12 34 56 78, then DE AD BE EF -> im_w pulses twice: addr 0 data 0x12345678, then addr 1 data 0xDEADBEEF. cpu_hold 1->0 and done=1 one cycle after the 2nd pulse; err=0.
2. Send 00 00 -> no im_w; done=1, cpu_hold=0 the cycle after the LEN_LO byte.
3. Send 00 01, 11 22, then a byte with stop bit = 0 -> err=1, cpu_hold stays 1, im_w never asserts, later bytes ignored.
4. Send 08 01 (N=2049 > MAX_WORDS) -> err=1, no writes.
5. Send 00 03, then a 2-cycle low glitch on uart_rx, then 3 valid words -> glitch rejected; writes at addresses 0,1,2 with correct data; done=1.
6. Assert reset after 6 bytes of an N=2 image, then send a complete N=1 image AA BB CC DD -> single write at addr 0 data 0xAABBCCDD; done=1.
